mem_rr_arbiter: RTL and testbench

MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_sp_mem.sv | 21 ++
 rtl/mem_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the three-requester memory arbiter: requester count,
// arbitration FSM states and the requester index type.
package mem_arb_pkg;

   localparam int NUM_REQ = 3;

   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   typedef logic [1:0] req_idx_t;

   // (base + off) mod NUM_REQ, used to rotate the search order.
   function automatic req_idx_t wrap_idx(input req_idx_t base, input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      return req_idx_t'(sum % NUM_REQ);
   endfunction

endpackage

// File: rtl/arb_sp_mem.sv
// Single-port synchronous memory: write on we, registered read of the
// addressed word every cycle. Contents are deliberately not reset.
module arb_sp_mem #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Three-requester arbiter in front of a single-port memory, with a
// hold-grant (lock) mode. Define ARB_RR_EN for round-robin arbitration;
// otherwise fixed priority 0 > 1 > 2 is used.
//
// Handshake: a transfer of requester i is accepted at a rising clk edge
// when req_valid[i] and req_ready[i] are both high; req_ready is
// combinational, never depends on itself, and at most one bit is set.
// A read accepted at edge N shows rsp_valid[i] with its data for the one
// cycle following edge N+1; writes produce no response.
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [WIDTH-1:0]          rsp_rdata,
   output logic                      busy,
   output arb_state_e                dbg_state,
   output req_idx_t                  dbg_ptr,
   output req_idx_t                  dbg_owner
);

   arb_state_e         state_q, state_d;
   req_idx_t           owner_q, owner_d;
   req_idx_t           search_base;
   req_idx_t           gnt_idx;
   logic               found;
   logic               accept;
   logic               rd_accept;
   logic [NUM_REQ-1:0] owner_mask;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] rd_pend_q;
   logic               mem_we;
   logic [ADDR_W-1:0]  mem_addr;
   logic [WIDTH-1:0]   mem_wdata;
   logic [WIDTH-1:0]   mem_rdata;

`ifdef ARB_RR_EN
   req_idx_t ptr_q;

   // The pointer moves only on an accepted transfer, to just past the winner.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        ptr_q <= '0;
      else if (accept) ptr_q <= wrap_idx(gnt_idx, 1);
   end

   assign search_base = ptr_q;
   assign dbg_ptr     = ptr_q;
`else
   assign search_base = '0;
   assign dbg_ptr     = '0;
`endif

   assign owner_mask = NUM_REQ'(1) << owner_q;
   assign elig       = (state_q == ST_ARB) ? req_valid : (req_valid & owner_mask);

   always_comb begin
      found     = 1'b0;
      gnt_idx   = '0;
      req_ready = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && elig[wrap_idx(search_base, k)]) begin
            found   = 1'b1;
            gnt_idx = wrap_idx(search_base, k);
         end
      end
      if (found) req_ready[gnt_idx] = 1'b1;
   end

   assign accept    = found;
   assign mem_we    = accept & req_we[gnt_idx];
   assign rd_accept = accept & ~req_we[gnt_idx];
   assign mem_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
   assign mem_wdata = req_wdata[int'(gnt_idx)*WIDTH +: WIDTH];

   arb_sp_mem #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_ARB;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // The owner losing valid releases the lock even with no transfer that cycle.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      unique case (state_q)
         ST_ARB: begin
            if (accept && req_lock[gnt_idx]) begin
               state_d = ST_LOCKED;
               owner_d = gnt_idx;
            end
         end
         ST_LOCKED: begin
            if (!req_valid[owner_q])              state_d = ST_ARB;
            else if (accept && !req_lock[owner_q]) state_d = ST_ARB;
         end
         default: state_d = ST_ARB;
      endcase
   end

   // Read pipeline: pending flag tracks the memory's registered read stage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pend_q <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
      end else begin
         rd_pend_q <= rd_accept ? req_ready : '0;
         rsp_valid <= rd_pend_q;
         if (|rd_pend_q) rsp_rdata <= mem_rdata;
      end
   end

   assign busy      = (state_q == ST_LOCKED) | (|rd_pend_q);
   assign dbg_state = state_q;
   assign dbg_owner = owner_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: a vector table for single-cycle
// behaviour plus directed sequences for arbitration, lock, streaming and reset.
module tb_mem_rr_arbiter;
   import mem_arb_pkg::*;

   localparam int WIDTH  = 8;
   localparam int ADDR_W = 4;

   logic                      clk;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*WIDTH-1:0]  req_wdata;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [WIDTH-1:0]          rsp_rdata;
   logic                      busy;
   arb_state_e                dbg_state;
   req_idx_t                  dbg_ptr;
   req_idx_t                  dbg_owner;

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] exp_q[$];

   mem_rr_arbiter #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_lock  (req_lock),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .dbg_state (dbg_state),
      .dbg_ptr   (dbg_ptr),
      .dbg_owner (dbg_owner)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  valid, we, lock;
      logic [11:0] addr;
      logic [23:0] wdata;
      logic [2:0]  exp_ready, exp_rsp;
      logic [7:0]  exp_rdata;
      logic        exp_busy;
   } vec_t;

   vec_t vec [12];

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 37 + 27);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] v, input logic [2:0] w, input logic [2:0] l,
                        input logic [11:0] a, input logic [23:0] d);
      req_valid = v;
      req_we    = w;
      req_lock  = l;
      req_addr  = a;
      req_wdata = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
      check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(0));
      check({tag, "_busy"},      32'(busy),      32'(0));
      check({tag, "_state"},     32'(dbg_state), 32'(ST_ARB));
      check({tag, "_ptr"},       32'(dbg_ptr),   32'(0));
      check({tag, "_owner"},     32'(dbg_owner), 32'(0));
   endtask

   initial begin
      logic [2:0] exp_g [8];
      logic [2:0] gexp;

      rst = 1'b0;
      drive(3'b000, 3'b000, 3'b000, 12'h000, 24'h000000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_values("por");
      check("por_ready", 32'(req_ready), 32'(0));
      tick();
      rst = 1'b1;

      // valid, we, lock, addr, wdata, exp_ready, exp_rsp, exp_rdata, exp_busy
      vec[0]  = '{3'b001, 3'b001, 3'b000, 12'h003, 24'h0000A5, 3'b001, 3'b000, 8'h00, 1'b0};
      vec[1]  = '{3'b010, 3'b000, 3'b000, 12'h030, 24'h000000, 3'b010, 3'b000, 8'h00, 1'b0};
      vec[2]  = '{3'b000, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 1'b1};
      vec[3]  = '{3'b000, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b010, 8'hA5, 1'b0};
      vec[4]  = '{3'b000, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 1'b0};
      vec[5]  = '{3'b100, 3'b100, 3'b000, 12'h700, 24'h3C0000, 3'b100, 3'b000, 8'h00, 1'b0};
      vec[6]  = '{3'b001, 3'b001, 3'b000, 12'h007, 24'h00005A, 3'b001, 3'b000, 8'h00, 1'b0};
      vec[7]  = '{3'b100, 3'b000, 3'b000, 12'h700, 24'h000000, 3'b100, 3'b000, 8'h00, 1'b0};
      vec[8]  = '{3'b001, 3'b000, 3'b000, 12'h003, 24'h000000, 3'b001, 3'b000, 8'h00, 1'b1};
      vec[9]  = '{3'b000, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b100, 8'h5A, 1'b1};
      vec[10] = '{3'b000, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b001, 8'hA5, 1'b0};
      vec[11] = '{3'b000, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 1'b0};

      for (int i = 0; i < 12; i++) begin
         drive(vec[i].valid, vec[i].we, vec[i].lock, vec[i].addr, vec[i].wdata);
         @(negedge clk);
         check($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vec[i].exp_ready));
         check($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vec[i].exp_rsp));
         if (vec[i].exp_rsp != 3'b000)
            check($sformatf("vec%0d_rdata", i), 32'(rsp_rdata), 32'(vec[i].exp_rdata));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vec[i].exp_busy));
         tick();
      end

      // Reset pulse so the arbitration order starts from requester 0.
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("pulse");
      tick();
      rst = 1'b1;

      // All three requesters read addr 3 for six cycles.
      for (int k = 0; k < 8; k++) begin
`ifdef ARB_RR_EN
         gexp = (k < 6) ? (3'b001 << (k % 3)) : 3'b000;
`else
         gexp = (k < 6) ? 3'b001 : 3'b000;
`endif
         exp_g[k] = gexp;
         if (k < 6) drive(3'b111, 3'b000, 3'b000, 12'h333, 24'h000000);
         else       drive(3'b000, 3'b000, 3'b000, 12'h000, 24'h000000);
         @(negedge clk);
         check($sformatf("order%0d_ready", k), 32'(req_ready), 32'(gexp));
         if (k >= 2) begin
            check($sformatf("order%0d_rsp_valid", k), 32'(rsp_valid), 32'(exp_g[k-2]));
            check($sformatf("order%0d_rdata", k), 32'(rsp_rdata), 32'(8'hA5));
         end
         tick();
      end

      // Lock: req2 alone takes the lock, then holds it while 0 and 1 wait.
      drive(3'b100, 3'b100, 3'b100, 12'h900, 24'h110000);
      @(negedge clk);
      check("lock_first_ready", 32'(req_ready), 32'(3'b100));
      check("lock_first_busy", 32'(busy), 32'(0));
      tick();
      for (int t = 1; t <= 4; t++) begin
         drive(3'b111, 3'b111, (t < 4) ? 3'b100 : 3'b000, 12'h9BA, {8'(t), 8'h22, 8'h33});
         @(negedge clk);
         check($sformatf("lock%0d_ready", t), 32'(req_ready), 32'(3'b100));
         check($sformatf("lock%0d_busy", t), 32'(busy), 32'(1));
         check($sformatf("lock%0d_state", t), 32'(dbg_state), 32'(ST_LOCKED));
         check($sformatf("lock%0d_owner", t), 32'(dbg_owner), 32'(2));
         tick();
      end
      drive(3'b111, 3'b111, 3'b000, 12'h9BA, 24'h445566);
      @(negedge clk);
      check("unlock_ready", 32'(req_ready), 32'(3'b001));
      check("unlock_busy", 32'(busy), 32'(0));
      check("unlock_state", 32'(dbg_state), 32'(ST_ARB));
      tick();

      // Owner drop: req0 locks, then its valid falls while 1 and 2 wait.
      drive(3'b001, 3'b001, 3'b001, 12'h00E, 24'h000077);
      @(negedge clk);
      check("drop_take_ready", 32'(req_ready), 32'(3'b001));
      tick();
      drive(3'b110, 3'b110, 3'b000, 12'hDC0, 24'h889900);
      @(negedge clk);
      check("drop_gap_ready", 32'(req_ready), 32'(3'b000));
      check("drop_gap_state", 32'(dbg_state), 32'(ST_LOCKED));
      check("drop_gap_busy", 32'(busy), 32'(1));
      tick();
      @(negedge clk);
      check("drop_next_ready", 32'(req_ready), 32'(3'b010));
      check("drop_next_state", 32'(dbg_state), 32'(ST_ARB));
      tick();

      // Streaming: req1 fills addresses 0..15, then reads them back-to-back.
      for (int i = 0; i < 16; i++) begin
         drive(3'b010, 3'b010, 3'b000, {4'h0, 4'(i), 4'h0}, {8'h00, pat(i), 8'h00});
         @(negedge clk);
         check($sformatf("fill%0d_ready", i), 32'(req_ready), 32'(3'b010));
         tick();
      end
      for (int k = 0; k < 18; k++) begin
         if (k < 16) drive(3'b010, 3'b000, 3'b000, {4'h0, 4'(k), 4'h0}, 24'h000000);
         else        drive(3'b000, 3'b000, 3'b000, 12'h000, 24'h000000);
         @(negedge clk);
         check($sformatf("stream%0d_ready", k), 32'(req_ready), 32'((k < 16) ? 3'b010 : 3'b000));
         if (k < 16 && req_ready == 3'b010) exp_q.push_back(pat(k));
         if (k >= 2) begin
            check($sformatf("stream%0d_rsp_valid", k), 32'(rsp_valid), 32'(3'b010));
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stream%0d_queue actual=empty expected=entry", k);
            end else begin
               check($sformatf("stream%0d_rdata", k), 32'(rsp_rdata), 32'(exp_q.pop_front()));
            end
         end else begin
            check($sformatf("stream%0d_rsp_idle", k), 32'(rsp_valid), 32'(3'b000));
         end
         tick();
      end
      check("stream_queue_empty", 32'(exp_q.size()), 32'(0));

      // Reset pulse the cycle after a locked read of addr 5 is accepted.
      drive(3'b001, 3'b000, 3'b001, 12'h005, 24'h000000);
      @(negedge clk);
      check("rstrd_ready", 32'(req_ready), 32'(3'b001));
      tick();
      drive(3'b000, 3'b000, 3'b000, 12'h000, 24'h000000);
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("rstrd");
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("rstrd_discard_rsp", 32'(rsp_valid), 32'(3'b000));
      check("rstrd_discard_state", 32'(dbg_state), 32'(ST_ARB));
      tick();
      drive(3'b001, 3'b000, 3'b000, 12'h005, 24'h000000);
      @(negedge clk);
      check("reread_ready", 32'(req_ready), 32'(3'b001));
      tick();
      drive(3'b000, 3'b000, 3'b000, 12'h000, 24'h000000);
      tick();
      @(negedge clk);
      check("reread_rsp_valid", 32'(rsp_valid), 32'(3'b001));
      check("reread_rdata", 32'(rsp_rdata), 32'(pat(5)));
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
